// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : RV32I memory pipeline stage. Holds the EX/MEM register, runs the
//             data-memory handshake, lane-aligns stores, extracts loads and
//             feeds the MEM/WB register.
//  Revision : 1.0 - initial release
// ============================================================================

package rv32i_types;
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
        logic       load_regfile;
    } rv32i_control_word;
endpackage

module mem_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       ex_alu_out,
    input  logic [31:0]       ex_rs2_out,
    input  rv32i_control_word ex_ctrl,
    input  logic [4:0]        ex_rd,
    input  logic [31:0]       ex_u_imm,
    output logic              stall,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [31:0]       dmem_address,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_mbe,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              wb_valid,
    output logic [31:0]       wb_alu_out,
    output logic [31:0]       wb_mem_rdata,
    output rv32i_control_word wb_ctrl,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_u_imm
);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_valid;
    logic [31:0]       r_alu;
    logic [31:0]       r_rs2;
    rv32i_control_word r_ctrl;
    logic [4:0]        r_rd;
    logic [31:0]       r_u_imm;

    logic              w_in_access;
    logic              w_ex_mem_op;
    logic [1:0]        w_lane;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;

    assign w_in_access  = (r_state == ST_ACCESS);
    assign w_ex_mem_op  = ex_valid && (ex_ctrl.mem_read || ex_ctrl.mem_write);
    assign w_lane       = r_alu[1:0];
    assign stall        = w_in_access && !dmem_resp;
    assign dmem_address = {r_alu[31:2], 2'b00};

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    // Next state and request strobes. A bubble never counts as a memory op,
    // so it can never start an access.
    always_comb begin
        w_state_next = r_state;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        if (!stall)
            w_state_next = w_ex_mem_op ? ST_ACCESS : ST_IDLE;
        if (w_in_access) begin
            dmem_read  = r_ctrl.mem_read;
            dmem_write = r_ctrl.mem_write;
        end
    end

    // Store lane alignment and byte enables; both come from the held entry so
    // they remain stable for the whole access.
    always_comb begin
        dmem_mbe   = 4'b0000;
        dmem_wdata = 32'h0;
        if (w_in_access) begin
            dmem_mbe = 4'b1111;
            if (r_ctrl.mem_write) begin
                case (r_ctrl.funct3)
                    c_F3_B: begin
                        dmem_mbe   = 4'b0001 << w_lane;
                        dmem_wdata = {24'h0, r_rs2[7:0]} << {w_lane, 3'b000};
                    end
                    c_F3_H: begin
                        dmem_mbe   = 4'b0011 << {w_lane[1], 1'b0};
                        dmem_wdata = {16'h0, r_rs2[15:0]} << {w_lane[1], 4'b0000};
                    end
                    default: begin
                        dmem_mbe   = 4'b1111;
                        dmem_wdata = r_rs2;
                    end
                endcase
            end
        end
    end

    // Load extraction; misaligned offsets simply select the truncated lane.
    always_comb begin
        case (w_lane)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = w_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_ctrl.funct3)
            c_F3_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: w_load_data = {24'h0, w_byte};
            c_F3_H:  w_load_data = {{16{w_half[15]}}, w_half};
            c_F3_HU: w_load_data = {16'h0, w_half};
            c_F3_W:  w_load_data = dmem_rdata;
            default: w_load_data = dmem_rdata;
        endcase
    end

    // EX/MEM register: captures the EX result whenever the stage is not held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_alu   <= 32'h0;
            r_rs2   <= 32'h0;
            r_ctrl  <= '0;
            r_rd    <= 5'd0;
            r_u_imm <= 32'h0;
        end else if (!stall) begin
            r_valid <= ex_valid;
            r_alu   <= ex_alu_out;
            r_rs2   <= ex_rs2_out;
            r_ctrl  <= ex_ctrl;
            r_rd    <= ex_rd;
            r_u_imm <= ex_u_imm;
        end
    end

    // MEM/WB register: retires the entry when the stage is free, else a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            wb_alu_out   <= 32'h0;
            wb_mem_rdata <= 32'h0;
            wb_ctrl      <= '0;
            wb_rd        <= 5'd0;
            wb_u_imm     <= 32'h0;
        end else if (!stall) begin
            wb_valid     <= r_valid;
            wb_alu_out   <= r_alu;
            wb_mem_rdata <= (r_valid && r_ctrl.mem_read) ? w_load_data : 32'h0;
            wb_ctrl      <= r_ctrl;
            wb_rd        <= r_rd;
            wb_u_imm     <= r_u_imm;
        end else begin
            wb_valid     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: directed scenarios followed
//             by randomized traffic against a cycle-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic [31:0]       ex_alu_out, ex_rs2_out, ex_u_imm;
    rv32i_control_word ex_ctrl;
    logic [4:0]        ex_rd;
    logic              stall, dmem_read, dmem_write;
    logic [31:0]       dmem_address, dmem_wdata, dmem_rdata;
    logic [3:0]        dmem_mbe;
    logic              dmem_resp;
    logic              wb_valid;
    logic [31:0]       wb_alu_out, wb_mem_rdata, wb_u_imm;
    rv32i_control_word wb_ctrl;
    logic [4:0]        wb_rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
        .ex_rs2_out(ex_rs2_out), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_u_imm(ex_u_imm),
        .stall(stall), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .wb_valid(wb_valid),
        .wb_alu_out(wb_alu_out), .wb_mem_rdata(wb_mem_rdata), .wb_ctrl(wb_ctrl),
        .wb_rd(wb_rd), .wb_u_imm(wb_u_imm)
    );

    // Reference model: the instruction currently held in MEM and the retired one.
    logic              m_valid, m_busy, m_new;
    logic [31:0]       m_alu, m_rs2, m_uimm;
    rv32i_control_word m_ctrl;
    logic [4:0]        m_rd;
    int                m_wait;
    logic              e_valid, e_known;
    logic [31:0]       e_alu, e_rdata, e_uimm;
    rv32i_control_word e_ctrl;
    logic [4:0]        e_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rv32i_control_word mk(input logic [2:0] f3, input logic rd_op, input logic wr_op);
        rv32i_control_word c;
        c = '0;
        c.opcode = 7'h13;
        c.funct3 = f3;
        c.mem_read = rd_op;
        c.mem_write = wr_op;
        c.load_regfile = !wr_op;
        return c;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] data);
        int unsigned a;
        logic [31:0] bsh, hsh;
        a   = addr % 4;
        bsh = (data >> (8 * a)) & 32'hFF;
        hsh = (data >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (bsh >= 32'h80) ? (bsh | 32'hFFFF_FF00) : bsh;
            3'd4:    return bsh;
            3'd1:    return (hsh >= 32'h8000) ? (hsh | 32'hFFFF_0000) : hsh;
            3'd5:    return hsh;
            default: return data;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_busy = 0; m_alu = 0; m_rs2 = 0; m_uimm = 0; m_ctrl = '0; m_rd = 0;
        e_valid = 0; e_known = 1; e_alu = 0; e_rdata = 0; e_uimm = 0; e_ctrl = '0; e_rd = 0;
    endtask

    // One clock cycle: drive inputs, check request side, clock, check WB side.
    task automatic step(input logic rn, input logic v, input logic [31:0] alu,
                        input logic [31:0] rs2, input rv32i_control_word c,
                        input logic [4:0] rd, input logic [31:0] uimm,
                        input logic rsp, input logic [31:0] rdat);
        logic exp_stall;
        int unsigned a;
        m_new = 0;
        @(negedge clk);
        rst = rn; ex_valid = v; ex_alu_out = alu; ex_rs2_out = rs2; ex_ctrl = c;
        ex_rd = rd; ex_u_imm = uimm; dmem_resp = rsp; dmem_rdata = rdat;
        #1;
        exp_stall = m_busy && !rsp;
        a = m_alu % 4;
        check("stall", {31'b0, stall}, {31'b0, exp_stall});
        check("dmem_read", {31'b0, dmem_read}, {31'b0, m_busy && m_ctrl.mem_read});
        check("dmem_write", {31'b0, dmem_write}, {31'b0, m_busy && m_ctrl.mem_write});
        if (m_busy) begin
            check("dmem_address", dmem_address, m_alu & 32'hFFFF_FFFC);
            if (m_ctrl.mem_write && m_ctrl.funct3 == 3'd0) begin
                check("mbe_sb", {28'b0, dmem_mbe}, 32'h1 << a);
                check("wdata_sb", dmem_wdata, (m_rs2 & 32'hFF) << (8 * a));
            end else if (m_ctrl.mem_write && m_ctrl.funct3 == 3'd1) begin
                check("mbe_sh", {28'b0, dmem_mbe}, 32'h3 << (2 * (a / 2)));
                check("wdata_sh", dmem_wdata, (m_rs2 & 32'hFFFF) << (16 * (a / 2)));
            end else begin
                check("mbe_word", {28'b0, dmem_mbe}, 32'hF);
                if (m_ctrl.mem_write) check("wdata_sw", dmem_wdata, m_rs2);
            end
        end
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else if (!exp_stall) begin
            e_valid = m_valid; e_alu = m_alu; e_ctrl = m_ctrl; e_rd = m_rd; e_uimm = m_uimm;
            e_rdata = (m_valid && m_ctrl.mem_read) ? load_value(m_ctrl.funct3, m_alu, rdat) : 32'h0;
            e_known = m_valid;
            m_valid = v; m_alu = alu; m_rs2 = rs2; m_ctrl = c; m_rd = rd; m_uimm = uimm;
            m_busy = v && (c.mem_read || c.mem_write);
            m_new = m_busy;
        end else begin
            e_valid = 0; e_known = 0;
        end
        #1;
        check("wb_valid", {31'b0, wb_valid}, {31'b0, e_valid});
        if (e_known) begin
            check("wb_alu_out", wb_alu_out, e_alu);
            check("wb_mem_rdata", wb_mem_rdata, e_rdata);
            check("wb_rd", {27'b0, wb_rd}, {27'b0, e_rd});
            check("wb_u_imm", wb_u_imm, e_uimm);
            check("wb_ctrl", {19'b0, wb_ctrl}, {19'b0, e_ctrl});
        end
    endtask

    task automatic idle(input logic rsp);
        step(1, 0, 0, 0, '0, 0, 0, rsp, 32'hDEAD_BEEF);
    endtask

    initial begin
        rv32i_control_word c;
        logic rsp, v;
        int kind;
        rst = 0; ex_valid = 0; ex_alu_out = 0; ex_rs2_out = 0; ex_ctrl = '0;
        ex_rd = 0; ex_u_imm = 0; dmem_resp = 0; dmem_rdata = 0; m_wait = 0;
        repeat (2) @(posedge clk);
        model_reset();
        step(0, 0, 0, 0, '0, 0, 0, 0, 0);

        // ALU op retires one edge after entering MEM.
        step(1, 1, 32'h10, 32'h0, mk(3'd0, 0, 0), 5'd5, 32'h0, 0, 0);
        idle(0);
        check("alu_wb_valid", {31'b0, wb_valid}, 32'h1);
        check("alu_wb_alu", wb_alu_out, 32'h10);
        check("alu_wb_rd", {27'b0, wb_rd}, 32'd5);

        // lb / lbu at 0x1003, response after three stall cycles.
        for (int u = 0; u < 2; u++) begin
            step(1, 1, 32'h1003, 0, mk(u == 0 ? 3'd0 : 3'd4, 1, 0), 5'd7, 0, 0, 0);
            idle(0);
            check("lb_address", dmem_address, 32'h1000);
            idle(0); idle(0);
            step(1, 0, 0, 0, '0, 0, 0, 1, 32'h80FF_1234);
            check("lb_data", wb_mem_rdata, u == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
        end

        // sh at 0x2002 holds its lanes until the response.
        step(1, 1, 32'h2002, 32'h0000_BEEF, mk(3'd1, 0, 1), 5'd0, 0, 0, 0);
        idle(0); idle(0);
        check("sh_write", {31'b0, dmem_write}, 32'h1);
        check("sh_mbe", {28'b0, dmem_mbe}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'hBEEF_0000);
        idle(1);

        // Back-to-back lw then sw with same-cycle responses.
        step(1, 1, 32'h100, 0, mk(3'd2, 1, 0), 5'd1, 0, 0, 0);
        step(1, 1, 32'h104, 32'h1234_5678, mk(3'd2, 0, 1), 5'd0, 0, 1, 32'hCAFE_F00D);
        check("b2b_first_alu", wb_alu_out, 32'h100);
        check("b2b_first_data", wb_mem_rdata, 32'hCAFE_F00D);
        check("b2b_still_access", {31'b0, dmem_write}, 32'h1);
        idle(1);
        check("b2b_second_valid", {31'b0, wb_valid}, 32'h1);
        check("b2b_second_alu", wb_alu_out, 32'h104);

        // Reset mid-access, then a stray response.
        step(1, 1, 32'h300, 0, mk(3'd2, 1, 0), 5'd2, 0, 0, 0);
        idle(0);
        step(0, 0, 0, 0, '0, 0, 0, 0, 0);
        check("rst_read_cleared", {31'b0, dmem_read}, 32'h0);
        idle(1);
        idle(0);

        // Bubble carrying mem_read issues nothing.
        step(1, 0, 32'h400, 0, mk(3'd2, 1, 0), 5'd3, 0, 0, 0);
        check("bubble_no_req", {31'b0, dmem_read}, 32'h0);
        idle(0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 2);
            v = ($urandom_range(0, 3) != 0);
            case (kind)
                0: c = mk(3'($urandom_range(0, 7)), 0, 0);
                1: begin
                    case ($urandom_range(0, 4))
                        0: c = mk(3'd0, 1, 0);
                        1: c = mk(3'd1, 1, 0);
                        2: c = mk(3'd2, 1, 0);
                        3: c = mk(3'd4, 1, 0);
                        default: c = mk(3'd5, 1, 0);
                    endcase
                end
                default: c = mk(3'($urandom_range(0, 2)), 0, 1);
            endcase
            c.opcode = 7'($urandom);
            rsp = m_busy ? (m_wait == 0) : ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 39) != 0), v, $urandom, $urandom, c,
                 5'($urandom), $urandom, rsp, $urandom);
            if (m_new) m_wait = $urandom_range(0, 3);
            else if (m_busy && m_wait > 0) m_wait--;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
